uart_rx: RTL and testbench

- 8N1 UART receiver: the receive-side counterpart of the UART_TX transmitter.
- Samples the asynchronous RsRx line using a single system clock and an internal bit-period counter. No separate UART clock is used.
- Recovers each byte LSB-first and presents it in a holding register with a valid/ack handshake.
- Flags framing errors and overruns. Sits between the board RX pin and the command/telemetry consumer logic.

---
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Runs entirely on the system clock. The line is
// sampled at bit midpoints that are timed by an internal bit-period counter.
//
// Ports
//   clk           system clock, rising edge
//   reset_b       asynchronous active-low reset
//   RsRx          serial line, idle high, asynchronous to clk
//   RX_Ack        consumer acknowledge; clears RX_Valid and RX_Overrun
//   RX_Data_out   last good received byte
//   RX_Valid      high from byte load until RX_Ack
//   RX_Overrun    sticky; a new byte overwrote an unacknowledged one
//   RX_Frame_Err  one-cycle pulse when a stop bit is sampled low
//   RX_Busy       high while a frame is in progress (START, DATA, STOP)
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       RsRx,
  input  logic       RX_Ack,
  output logic [7:0] RX_Data_out,
  output logic       RX_Valid,
  output logic       RX_Overrun,
  output logic       RX_Frame_Err,
  output logic       RX_Busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfTerm = CntW'(HALF_BIT - 1);
  localparam logic [CntW-1:0] BitTerm  = CntW'(CLKS_PER_BIT - 1);
  // The synchronizer resets to 1, so rx_s reads high for up to two cycles after
  // reset release no matter what the line is doing. WAIT_IDLE ignores rx_s until
  // those stale values have been flushed out.
  localparam logic [CntW-1:0] SettleCnt = CntW'(2);

  typedef enum logic [2:0] {
    StWaitIdle,
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          r_state;
  logic            r_sync1;
  logic            r_rx_s;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shreg;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_overrun;
  logic            r_frame_err;
  logic            r_busy;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state     <= StWaitIdle;
      r_sync1     <= 1'b1;
      r_rx_s      <= 1'b1;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shreg     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sync1     <= RsRx;
      r_rx_s      <= r_sync1;
      r_frame_err <= 1'b0;

      // A load in the STOP branch below takes priority over this clear.
      if (RX_Ack) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end

      case (r_state)
        StWaitIdle: begin
          if (r_cnt != SettleCnt) begin
            r_cnt <= r_cnt + CntW'(1);
          end else if (r_rx_s) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end
        end

        StIdle: begin
          r_cnt <= '0;
          if (!r_rx_s) begin
            r_state <= StStart;
            r_busy  <= 1'b1;
          end
        end

        StStart: begin
          if (r_cnt == HalfTerm) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state   <= StData;
              r_bit_idx <= '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end

        StData: begin
          if (r_cnt == BitTerm) begin
            r_cnt     <= '0;
            r_shreg   <= {r_rx_s, r_shreg[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= StStop;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end

        StStop: begin
          if (r_cnt == BitTerm) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            if (r_rx_s) begin
              r_data    <= r_shreg;
              r_valid   <= 1'b1;
              // An ack landing on the load cycle retires the old byte cleanly.
              r_overrun <= r_overrun | (r_valid & ~RX_Ack);
              r_state   <= StIdle;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= StWaitIdle;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end

        default: begin
          r_state <= StWaitIdle;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign RX_Data_out  = r_data;
  assign RX_Valid     = r_valid;
  assign RX_Overrun   = r_overrun;
  assign RX_Frame_Err = r_frame_err;
  assign RX_Busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns / 1ps
module tb_uart_rx;

  localparam int unsigned Clks  = 16;
  localparam int          BitNs = 160;  // 16 clocks of 10 ns

  logic       clk;
  logic       reset_b;
  logic       RsRx;
  logic       RX_Ack;
  logic [7:0] RX_Data_out;
  logic       RX_Valid;
  logic       RX_Overrun;
  logic       RX_Frame_Err;
  logic       RX_Busy;

  uart_rx #(
    .CLKS_PER_BIT(Clks)
  ) dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .RsRx        (RsRx),
    .RX_Ack      (RX_Ack),
    .RX_Data_out (RX_Data_out),
    .RX_Valid    (RX_Valid),
    .RX_Overrun  (RX_Overrun),
    .RX_Frame_Err(RX_Frame_Err),
    .RX_Busy     (RX_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] sb_q[$];
  int         fe_cnt     = 0;
  int         fe_exp     = 0;
  logic       prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rising edge of RX_Valid must match the oldest pushed byte.
  always @(negedge clk) begin
    if (RX_Valid && !prev_valid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got byte 0x%0h, expected no byte", RX_Data_out);
      end else begin
        logic [7:0] exp_b;
        exp_b = sb_q.pop_front();
        if (RX_Data_out !== exp_b) begin
          n_fail++;
          $display("FAIL sb_data: got 0x%0h, expected 0x%0h", RX_Data_out, exp_b);
        end
      end
    end
    if (RX_Frame_Err === 1'b1) fe_cnt++;
    prev_valid = RX_Valid;
  end

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bit_ns);
    RsRx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      #(bit_ns);
    end
    RsRx = stop_ok;
    #(bit_ns);
    RsRx = 1'b1;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    RX_Ack = 1'b1;
    @(posedge clk);
    #1;
    RX_Ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         bit_ns;
  } vec_t;

  vec_t vecs[8];
  int   lat;

  initial begin
    // Frames received with RX_Ack held high, so every load coincides with an ack.
    vecs[0] = '{8'h41, 1'b1, BitNs};
    vecs[1] = '{8'h55, 1'b0, BitNs};  // stop bit low
    vecs[2] = '{8'hA3, 1'b1, BitNs};
    vecs[3] = '{8'hC5, 1'b1, 155};    // ~3% fast
    vecs[4] = '{8'h3A, 1'b1, 165};    // ~3% slow
    vecs[5] = '{8'hFF, 1'b1, 155};
    vecs[6] = '{8'h81, 1'b1, 165};
    vecs[7] = '{8'h00, 1'b1, 165};

    RsRx    = 1'b1;
    RX_Ack  = 1'b0;
    reset_b = 1'b0;
    #23;
    check("rst_data", 32'(RX_Data_out), 32'h0);
    check("rst_valid", 32'(RX_Valid), 32'h0);
    check("rst_overrun", 32'(RX_Overrun), 32'h0);
    check("rst_frame_err", 32'(RX_Frame_Err), 32'h0);
    check("rst_busy", 32'(RX_Busy), 32'h0);
    reset_b = 1'b1;
    repeat (10) @(negedge clk);

    // Single byte, latency window, ack clears valid next cycle.
    sb_q.push_back(8'h41);
    @(negedge clk);
    lat = 0;
    fork
      send_frame(8'h41, 1'b1, BitNs);
      begin
        for (int c = 1; c <= 200; c++) begin
          @(posedge clk);
          #1;
          if (RX_Valid) begin
            lat = c;
            break;
          end
        end
      end
    join
    check("latency_in_window", 32'(lat >= 152 && lat <= 160), 32'h1);
    check("single_data", 32'(RX_Data_out), 32'h41);
    check("single_valid", 32'(RX_Valid), 32'h1);
    check("single_overrun", 32'(RX_Overrun), 32'h0);
    check("single_frame_err", 32'(fe_cnt), 32'(fe_exp));
    pulse_ack();
    check("ack_clears_valid", 32'(RX_Valid), 32'h0);

    // Back-to-back without ack: overwrite and overrun.
    sb_q.push_back(8'h41);
    @(negedge clk);
    send_frame(8'h41, 1'b1, BitNs);
    send_frame(8'h46, 1'b1, BitNs);
    repeat (20) @(negedge clk);
    check("b2b_data", 32'(RX_Data_out), 32'h46);
    check("b2b_valid", 32'(RX_Valid), 32'h1);
    check("b2b_overrun", 32'(RX_Overrun), 32'h1);
    pulse_ack();
    check("b2b_ack_valid", 32'(RX_Valid), 32'h0);
    check("b2b_ack_overrun", 32'(RX_Overrun), 32'h0);

    // Table: frame error, recovery, rate error, ack coincident with load.
    RX_Ack = 1'b1;
    foreach (vecs[k]) begin
      if (vecs[k].stop_ok) sb_q.push_back(vecs[k].data);
      else fe_exp++;
      @(negedge clk);
      send_frame(vecs[k].data, vecs[k].stop_ok, vecs[k].bit_ns);
      repeat (40) @(negedge clk);
      check($sformatf("tbl%0d_drained", k), 32'(sb_q.size()), 32'h0);
      check($sformatf("tbl%0d_frame_err_cnt", k), 32'(fe_cnt), 32'(fe_exp));
      check($sformatf("tbl%0d_overrun", k), 32'(RX_Overrun), 32'h0);
      check($sformatf("tbl%0d_valid", k), 32'(RX_Valid), 32'h0);
    end
    RX_Ack = 1'b0;

    // Short low glitch on an idle line is rejected silently.
    @(negedge clk);
    RsRx = 1'b0;
    repeat (5) @(negedge clk);
    RsRx = 1'b1;
    repeat (3 * Clks) @(negedge clk);
    check("glitch_valid", 32'(RX_Valid), 32'h0);
    check("glitch_busy", 32'(RX_Busy), 32'h0);
    check("glitch_frame_err", 32'(fe_cnt), 32'(fe_exp));
    sb_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, BitNs);
    repeat (20) @(negedge clk);
    check("glitch_next_drained", 32'(sb_q.size()), 32'h0);
    check("glitch_next_data", 32'(RX_Data_out), 32'h00);
    pulse_ack();

    // Reset during data bit 3; release with the line low; no byte may appear.
    @(negedge clk);
    RsRx = 1'b0;
    #(BitNs);
    RsRx = 1'b1;
    #(3 * BitNs + BitNs / 2);
    check("midframe_busy", 32'(RX_Busy), 32'h1);
    reset_b = 1'b0;
    RsRx    = 1'b0;
    #1;
    check("midrst_busy", 32'(RX_Busy), 32'h0);
    check("midrst_data", 32'(RX_Data_out), 32'h0);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    #(2 * BitNs);
    check("post_rst_busy_low_line", 32'(RX_Busy), 32'h0);
    RsRx = 1'b1;
    #(4 * BitNs);
    check("post_rst_valid", 32'(RX_Valid), 32'h0);
    check("post_rst_frame_err", 32'(fe_cnt), 32'(fe_exp));
    sb_q.push_back(8'h3C);
    @(negedge clk);
    send_frame(8'h3C, 1'b1, BitNs);
    repeat (20) @(negedge clk);
    check("post_rst_drained", 32'(sb_q.size()), 32'h0);
    check("post_rst_data", 32'(RX_Data_out), 32'h3C);
    check("post_rst_valid_set", 32'(RX_Valid), 32'h1);
    check("post_rst_overrun", 32'(RX_Overrun), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
